// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight gshare predictions; resolves the oldest entry,
// drives the predictor's write side, and flushes wrong-path entries on mispredict.
module branch_resolve_queue #(
  parameter int unsigned HISTORY_LEN = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PTR_W       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_valid,
  input  logic [HISTORY_LEN-1:0] pred_pc_bits,
  input  logic [HISTORY_LEN-1:0] pred_history,
  input  logic                   pred_taken,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   update_en,
  output logic [HISTORY_LEN-1:0] pc_bits_write,
  output logic [HISTORY_LEN-1:0] history_write,
  output logic                   outcome,
  output logic                   mispredict,
  output logic [HISTORY_LEN-1:0] recover_history,
  output logic [PTR_W:0]         count,
  output logic                   underflow
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [HISTORY_LEN-1:0] pc_bits;
    logic [HISTORY_LEN-1:0] history;
    logic                   taken;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [PTR_W-1:0]       rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0]       count_nxt;
  logic                   update_en_nxt, mispredict_nxt, outcome_nxt, underflow_nxt;
  logic [HISTORY_LEN-1:0] pc_bits_write_nxt, history_write_nxt, recover_history_nxt;

  entry_t head_c;
  logic   full_c, empty_c, res_acc_c, mis_c, enq_acc_c;

  assign head_c     = mem[rd_ptr];
  assign full_c     = (count == CNT_W'(DEPTH));
  assign empty_c    = (count == '0);
  assign pred_ready = !full_c;

  // A mispredicting resolve squashes any same-cycle push: it is wrong-path.
  assign res_acc_c = res_valid && !empty_c;
  assign mis_c     = res_acc_c && (head_c.taken != res_taken);
  assign enq_acc_c = pred_valid && !full_c && !mis_c;

  always_comb begin
    rd_ptr_nxt          = rd_ptr;
    wr_ptr_nxt          = wr_ptr;
    count_nxt           = count;
    update_en_nxt       = 1'b0;
    mispredict_nxt      = 1'b0;
    outcome_nxt         = outcome;
    pc_bits_write_nxt   = pc_bits_write;
    history_write_nxt   = history_write;
    recover_history_nxt = recover_history;
    underflow_nxt       = underflow | (res_valid && empty_c);

    if (res_acc_c) begin
      rd_ptr_nxt          = rd_ptr + PTR_W'(1);
      update_en_nxt       = 1'b1;
      mispredict_nxt      = mis_c;
      outcome_nxt         = res_taken;
      pc_bits_write_nxt   = head_c.pc_bits;
      history_write_nxt   = head_c.history;
      recover_history_nxt = {head_c.history[HISTORY_LEN-2:0], res_taken};
    end

    if (mis_c) begin
      // Flush: everything younger than the resolved entry is discarded.
      wr_ptr_nxt = rd_ptr + PTR_W'(1);
      count_nxt  = '0;
    end else begin
      if (enq_acc_c) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      count_nxt = count + CNT_W'(enq_acc_c) - CNT_W'(res_acc_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      update_en       <= 1'b0;
      mispredict      <= 1'b0;
      outcome         <= 1'b0;
      pc_bits_write   <= '0;
      history_write   <= '0;
      recover_history <= '0;
      underflow       <= 1'b0;
    end else begin
      rd_ptr          <= rd_ptr_nxt;
      wr_ptr          <= wr_ptr_nxt;
      count           <= count_nxt;
      update_en       <= update_en_nxt;
      mispredict      <= mispredict_nxt;
      outcome         <= outcome_nxt;
      pc_bits_write   <= pc_bits_write_nxt;
      history_write   <= history_write_nxt;
      recover_history <= recover_history_nxt;
      underflow       <= underflow_nxt;
    end
  end

  // Entry storage is not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (enq_acc_c) begin
      mem[wr_ptr] <= '{pc_bits: pred_pc_bits, history: pred_history, taken: pred_taken};
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: a queue-based reference model predicts
// each resolve pulse and occupancy; a negedge monitor compares against the DUT.
module tb_branch_resolve_queue;

  localparam int unsigned HL    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pred_valid = 1'b0;
  logic [HL-1:0] pred_pc_bits = '0;
  logic [HL-1:0] pred_history = '0;
  logic          pred_taken = 1'b0;
  logic          pred_ready;
  logic          res_valid = 1'b0;
  logic          res_taken = 1'b0;
  logic          update_en;
  logic [HL-1:0] pc_bits_write;
  logic [HL-1:0] history_write;
  logic          outcome;
  logic          mispredict;
  logic [HL-1:0] recover_history;
  logic [PTR_W:0] count;
  logic          underflow;

  branch_resolve_queue #(.HISTORY_LEN(HL), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc_bits(pred_pc_bits), .pred_history(pred_history),
    .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .update_en(update_en), .pc_bits_write(pc_bits_write), .history_write(history_write),
    .outcome(outcome), .mispredict(mispredict), .recover_history(recover_history),
    .count(count), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [HL-1:0] pc;
    logic [HL-1:0] hist;
    logic          taken;
  } ent_t;

  typedef struct {
    logic [HL-1:0] pc;
    logic [HL-1:0] hist;
    logic          outc;
    logic          mis;
    logic [HL-1:0] rec;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  logic m_under = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: occupancy/status every cycle, pulse contents popped from the scoreboard.
  always @(negedge clk) begin
    check("count", 32'(count), 32'(mq.size()));
    check("pred_ready", 32'(pred_ready), 32'(mq.size() != DEPTH));
    check("underflow", 32'(underflow), 32'(m_under));
    if (update_en) begin
      if (sb.size() == 0) begin
        check("unexpected_update_en", 32'(update_en), 32'(0));
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("pc_bits_write", 32'(pc_bits_write), 32'(x.pc));
        check("history_write", 32'(history_write), 32'(x.hist));
        check("outcome", 32'(outcome), 32'(x.outc));
        check("mispredict", 32'(mispredict), 32'(x.mis));
        if (x.mis) check("recover_history", 32'(recover_history), 32'(x.rec));
      end
    end else begin
      check("missing_update_en", 32'(sb.size()), 32'(0));
      check("mispredict_idle", 32'(mispredict), 32'(0));
    end
  end

  // Drive one cycle of stimulus; the model advances at the same edge as the DUT.
  task automatic step(input logic pv, input logic [HL-1:0] pc, input logic [HL-1:0] h,
                      input logic pt, input logic rv, input logic rt);
    logic res_ok, mis, enq_ok;
    exp_t x;
    pred_valid   = pv;
    pred_pc_bits = pc;
    pred_history = h;
    pred_taken   = pt;
    res_valid    = rv;
    res_taken    = rt;
    res_ok = rv && (mq.size() != 0);
    mis    = 1'b0;
    x      = '{default: '0};
    if (res_ok) begin
      mis = (mq[0].taken != rt);
      x   = '{pc: mq[0].pc, hist: mq[0].hist, outc: rt, mis: mis,
              rec: ((mq[0].hist << 1) | HL'(rt))};
    end
    enq_ok = pv && (mq.size() != DEPTH) && !mis;
    @(posedge clk);
    if (res_ok) begin
      void'(mq.pop_front());
      sb.push_back(x);
    end
    if (mis) mq.delete();
    if (enq_ok) mq.push_back('{pc: pc, hist: h, taken: pt});
    if (rv && !res_ok) m_under = 1'b1;
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [HL-1:0] r_pc, r_h;
  logic          r_pt, r_pv, r_rv, r_rt;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    idle(10);

    // Single push, correct resolve
    step(1'b1, 8'h3A, 8'h55, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Fill to full, ignored 5th push, FIFO drain; twice to wrap pointers
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++)
        step(1'b1, HL'(8'h10 + 8'(pass * 8 + i)), HL'(8'hA0 + 8'(i)), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      idle(1);
    end

    // Mispredict on oldest while pushing: flush, push dropped
    step(1'b1, 8'h01, 8'h81, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 8'h12, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h03, 8'h13, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h04, 8'h14, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Underflow is sticky across normal traffic
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h77, 8'h66, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h78, 8'h67, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Asynchronous reset mid-cycle with two entries and a pending pulse
    step(1'b1, 8'h21, 8'h31, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h22, 8'h32, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h23, 8'h33, 1'b0, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    mq.delete();
    sb.delete();
    m_under = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'(0));
    check("rst_update_en", 32'(update_en), 32'(0));
    check("rst_mispredict", 32'(mispredict), 32'(0));
    check("rst_underflow", 32'(underflow), 32'(0));
    check("rst_pc_bits_write", 32'(pc_bits_write), 32'(0));
    check("rst_history_write", 32'(history_write), 32'(0));
    check("rst_outcome", 32'(outcome), 32'(0));
    check("rst_recover_history", 32'(recover_history), 32'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Random traffic, mostly-correct predictions so the queue fills at times
    for (int i = 0; i < 1500; i++) begin
      r_pc = HL'($urandom);
      r_h  = HL'($urandom);
      r_pt = 1'($urandom);
      r_pv = ($urandom_range(0, 99) < 65);
      r_rv = ($urandom_range(0, 99) < 45);
      r_rt = ($urandom_range(0, 99) < 85) ? (mq.size() != 0 ? mq[0].taken : r_pt) : 1'($urandom);
      step(r_pv, r_pc, r_h, r_pt, r_rv, r_rt);
    end

    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order tracker for branch predictions in flight between fetch and execute.
- Fetch pushes each gshare prediction with the PC index bits and global-history snapshot used to make it. Execute later resolves the oldest entry with the actual outcome.
- The block drives the gshare predictor's write side: update_en, pc_bits_write, history_write and outcome. It also raises a mispredict/flush pulse carrying the corrected history.

Parameters:
- HISTORY_LEN, 8, width of history and PC index bits; must match the predictor.
- DEPTH, 4, queue entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pred_valid  input  1  fetch pushes a prediction this cycle.
- pred_pc_bits  input  HISTORY_LEN  PC index bits used for the read.
- pred_history  input  HISTORY_LEN  global history used for the read.
- pred_taken  input  1  predicted direction (predictor count[1]).
- pred_ready  output  1  queue not full; equals (count != DEPTH), combinational.
- res_valid  input  1  execute resolves the oldest branch this cycle.
- res_taken  input  1  actual outcome.
- update_en  output  1  registered one-cycle pulse to the predictor.
- pc_bits_write  output  HISTORY_LEN  resolved entry's PC bits.
- history_write  output  HISTORY_LEN  resolved entry's history snapshot.
- outcome  output  1  actual outcome of the resolved entry.
- mispredict  output  1  registered one-cycle pulse; asserted with update_en when predicted != actual.
- recover_history  output  HISTORY_LEN  {history_write[HISTORY_LEN-2:0], outcome}; valid while mispredict is high.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- underflow  output  1  sticky: res_valid was seen while the queue was empty.

Behaviour:
- Reset (async, immediate): rd_ptr=0, wr_ptr=0, count=0. update_en=0, mispredict=0, underflow=0. pc_bits_write, history_write, outcome and recover_history are all 0. Entry storage need not be cleared.
- Storage: circular buffer of DEPTH entries, each {pc_bits, history, taken}. Pointers wrap modulo DEPTH. Full/empty is decided by count, not pointer equality.
- Enqueue: accepted at a rising edge when pred_valid && pred_ready and no mispredict flush occurs on that edge. The entry is written at wr_ptr, then wr_ptr increments.
- Resolve: accepted at a rising edge when res_valid && count!=0. The entry at rd_ptr is read, rd_ptr increments, and the output registers load:
  - update_en=1
  - pc_bits_write, history_write = the entry's fields
  - outcome = res_taken
  - mispredict = (entry.taken != res_taken)
- Latency: resolve at edge N gives update_en/mispredict high for exactly the cycle after edge N. Both are 0 in every cycle without an accepted resolve. Data outputs hold their last value when update_en=0.
- Flush: a mispredicting resolve at edge N empties the queue at edge N. Specifically, wr_ptr = rd_ptr+1 (post-pop value) and count=0, so all younger wrong-path entries are discarded.
- Simultaneous enqueue and mispredicting resolve: the enqueue is dropped, because the pushed instruction is wrong-path.
- Simultaneous enqueue and correct resolve: both take effect and count is unchanged.
- When full, pred_ready=0 even if a resolve occurs in the same cycle, so there is no same-cycle bypass. Enqueue attempts while full are ignored, with no state change.
- Underflow: res_valid with count==0 is ignored. No update_en is produced and underflow sets to 1, staying set until reset.
- Reset asserted mid-operation discards all entries and any pending pulse immediately.
- The block has no combinational path from res_* to any output; only pred_ready depends on internal state.

Test Plan:
- Reset then idle -> count=0, pred_ready=1, update_en=0, mispredict=0, underflow=0 for 10 cycles.
- Push {pc=0x3A, hist=0x55, taken=1}, then resolve with res_taken=1 -> the next cycle shows update_en=1, pc_bits_write=0x3A, history_write=0x55, outcome=1, mispredict=0. count goes 1 -> 0.
- Push 4 entries (DEPTH=4) -> pred_ready=0 and count=4. A 5th push is ignored. Then 4 correct resolves drain the entries in FIFO order with matching pc/hist, and pointers wrap correctly on a second fill.
- Push 3 entries, the first with taken=0 and hist=0x81. Resolve the first with res_taken=1 while pushing a 4th -> mispredict=1 and recover_history=0x03. count=0 afterwards (the 4th push is dropped), and pred_ready=1.
- res_valid with the queue empty -> no update_en, underflow=1 and stays 1 after later normal traffic until reset.
- Fill 2 entries, assert reset asynchronously mid-cycle -> count=0 and all outputs 0 immediately, without waiting for a clock edge. A resolve after reset release sets underflow.
